// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per clock into a 32x32 file.
// Optional SM4_KEYEXP_DEC_EN adds a 'dec' input that reverses the read index.
// Handshake: start is taken only in IDLE; rk_valid marks a one-cycle beat.

module sm4_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign out_o = SBOX[in_i];
endmodule

module sm4_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] MK,
`ifdef SM4_KEYEXP_DEC_EN
    input  logic         dec,
`endif
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         rk_valid,
    output logic [4:0]   rk_idx,
    output logic [31:0]  rk_out,
    input  logic [4:0]   rd_addr,
    output logic [31:0]  rd_rk
);
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [127:0]  k_q;
    logic [4:0]    cnt_q;
    logic          busy_q, done_q, key_ready_q, rk_valid_q;
    logic [4:0]    rk_idx_q;
    logic [31:0]   rk_out_q;
    logic [31:0]   file_q [32];

    logic          accept, last_round;
    logic [7:0]    ck_base;
    logic [31:0]   ck, t, tau, rk;

    assign accept     = (state_q == S_IDLE) && start;
    assign last_round = (state_q == S_RUN) && (cnt_q == 5'd31);

    // CK byte j of round i is 7*(4i+j) mod 256, so bytes step by 7 from 28*i.
    assign ck_base = {1'b0, cnt_q, 2'b00} * 8'd7;
    assign ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
    assign t       = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_i  (t[31-8*g -: 8]),
            .out_o (tau[31-8*g -: 8])
        );
    end

    assign rk = k_q[127:96] ^ tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_idx_q    <= '0;
            rk_out_q    <= '0;
            for (int i = 0; i < 32; i++) file_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rk_valid_q <= (state_q == S_RUN);
            done_q     <= last_round;
            if (accept) begin
                k_q         <= MK ^ FK;
                cnt_q       <= '0;
                busy_q      <= 1'b1;
                key_ready_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                file_q[cnt_q] <= rk;
                k_q           <= {k_q[95:0], rk};
                rk_out_q      <= rk;
                rk_idx_q      <= cnt_q;
                cnt_q         <= cnt_q + 5'd1;
                if (last_round) begin
                    busy_q      <= 1'b0;
                    key_ready_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_idx    = rk_idx_q;
    assign rk_out    = rk_out_q;

`ifdef SM4_KEYEXP_DEC_EN
    // Reversed index lets decryption walk the same 0..31 address sequence.
    assign rd_rk = dec ? file_q[~rd_addr] : file_q[rd_addr];
`else
    assign rd_rk = file_q[rd_addr];
`endif
endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: reference key schedule model, rk stream scoreboard,
// known-answer, read-back, abort, ignore-start and back-to-back scenarios.

module tb_sm4_key_expand;
    localparam logic [127:0] T1_MK = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [31:0]  FK_W [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    localparam logic [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic         clk, rst_n, start, dec;
    logic [127:0] MK;
    logic         busy, done, key_ready, rk_valid;
    logic [4:0]   rk_idx, rd_addr;
    logic [31:0]  rk_out, rd_rk;

    int           pass_cnt = 0;
    int           tot_cnt  = 0;
    int           cyc      = 0;
    logic [36:0]  exp_q[$];
    logic [36:0]  mon_exp;
    logic [31:0]  ref_rk [32];

    sm4_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .MK        (MK),
`ifdef SM4_KEYEXP_DEC_EN
        .dec       (dec),
`endif
        .busy      (busy),
        .done      (done),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rd_addr   (rd_addr),
        .rd_rk     (rd_rk)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, tot_cnt);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference schedule: K[i+4] = K[i] ^ L'(tau(K[i+1]^K[i+2]^K[i+3]^CK[i]))
    task automatic ref_keys(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck, x, tau;
        for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ FK_W[j];
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
            tau = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
            k[i+4] = k[i] ^ tau ^ rotl(tau, 13) ^ rotl(tau, 23);
            ref_rk[i] = k[i+4];
        end
    endtask

    task automatic push_exp(input logic [127:0] mk);
        ref_keys(mk);
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), ref_rk[i]});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && rk_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rk_valid", {5'd0, rk_idx, rk_out}, 64'h0);
            else begin
                mon_exp = exp_q.pop_front();
                chk("rk_stream", {27'd0, rk_idx, rk_out}, {27'd0, mon_exp});
            end
        end
    end

    task automatic expand(input logic [127:0] mk, output int acc);
        @(negedge clk);
        MK = mk;
        start = 1'b1;
        @(negedge clk);
        acc = cyc;
        start = 1'b0;
        push_exp(mk);
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("key_ready_low_in_run", 64'(key_ready), 64'd0);
    endtask

    task automatic wait_done(input int acc);
        int dc;
        dc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
        else begin
            chk("done_latency", 64'(dc - acc), 64'd32);
            chk("busy_low_at_done", 64'(busy), 64'd0);
            chk("key_ready_at_done", 64'(key_ready), 64'd1);
            @(negedge clk);
            chk("done_one_pulse", 64'(done), 64'd0);
            chk("key_ready_held", 64'(key_ready), 64'd1);
        end
    endtask

    task automatic check_reads();
        int order [32];
        int j, tmp;
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(order[i]);
            #1;
            chk("rd_rk_readback", 64'(rd_rk), 64'(ref_rk[order[i]]));
        end
    endtask

    task automatic rd_const(input logic [4:0] a, input logic [31:0] exp, input string name);
        rd_addr = a;
        #1;
        chk(name, 64'(rd_rk), 64'(exp));
    endtask

    initial begin
        int acc;
        int acc_c [$];
        int dn_c [$];
        logic prev_busy;
        rst_n = 1'b0; start = 1'b0; MK = '0; rd_addr = '0; dec = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_rk_valid", 64'(rk_valid), 64'd0);
        chk("rst_rk_idx_out", {27'd0, rk_idx, rk_out}, 64'd0);
        rd_const(5'd17, 32'h0, "rst_file");
        rst_n = 1'b1;

        // T1 known answer, T2 read-back
        expand(T1_MK, acc);
        wait_done(acc);
        rd_const(5'd0,  32'hF12186F9, "t1_rk0");
        rd_const(5'd1,  32'h41662B61, "t1_rk1");
        rd_const(5'd31, 32'h9124A012, "t1_rk31");
        check_reads();
`ifdef SM4_KEYEXP_DEC_EN
        dec = 1'b1;
        rd_const(5'd0, 32'h9124A012, "dec_rd0");
        rd_const(5'd31, 32'hF12186F9, "dec_rd31");
        dec = 1'b0;
`endif

        // T3 stray start mid-run is ignored
        expand(T1_MK, acc);
        repeat (9) @(negedge clk);
        MK = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(acc);
        rd_const(5'd31, 32'h9124A012, "t3_rk31");
        check_reads();

        // T4 reset during round 15
        expand(T1_MK, acc);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_key_ready", 64'(key_ready), 64'd0);
        chk("abort_rk_valid_idx_out", {26'd0, rk_valid, rk_idx, rk_out}, 64'd0);
        rd_const(5'd3, 32'h0, "abort_file");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) chk("abort_no_done", {62'd0, done, busy}, 64'd0);
        end
        expand(T1_MK, acc);
        wait_done(acc);
        rd_const(5'd31, 32'h9124A012, "t4_restart_rk31");

        // T5 zero key, MK changed during run
        expand(128'h0, acc);
        repeat (5) @(negedge clk);
        MK = {$urandom, $urandom, $urandom, $urandom};
        chk("t5_key_ready_low", 64'(key_ready), 64'd0);
        wait_done(acc);
        check_reads();

        // random keys
        for (int r = 0; r < 3; r++) begin
            expand({$urandom, $urandom, $urandom, $urandom}, acc);
            wait_done(acc);
            check_reads();
        end

        // T6 start held: two back-to-back expansions
        @(negedge clk);
        MK = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        push_exp(MK);
        push_exp(MK);
        prev_busy = busy;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 59) start = 1'b0;
            if (busy && !prev_busy) acc_c.push_back(cyc);
            if (done) dn_c.push_back(cyc);
            prev_busy = busy;
        end
        chk("t6_accept_count", 64'(acc_c.size()), 64'd2);
        chk("t6_done_count", 64'(dn_c.size()), 64'd2);
        if (acc_c.size() == 2 && dn_c.size() == 2) begin
            chk("t6_latency0", 64'(dn_c[0] - acc_c[0]), 64'd32);
            chk("t6_latency1", 64'(dn_c[1] - acc_c[1]), 64'd32);
            chk("t6_gap", 64'(acc_c[1] - dn_c[0]), 64'd2);
        end
        check_reads();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
